// File: rtl/cmp_pkg.sv
// +----------------------------------------------------------------------------+
// | cmp_pkg : shared types and helpers for serial_magnitude_comparator         |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_LT = 2'd0,
    RES_EQ = 2'd1,
    RES_GT = 2'd2
  } res_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_cmp.sv
// +----------------------------------------------------------------------------+
// | digit_cmp : combinational unsigned compare of one DIGIT-bit slice          |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module digit_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
// +----------------------------------------------------------------------------+
// | serial_magnitude_comparator : MSB-first digit-serial compare, early stop.  |
// | Optional outcome counters when CMP_STATS_EN is defined.                    |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater
`ifdef CMP_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_less,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_greater
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  generate
    if (((WIDTH % DIGIT) != 0) || (CNT_W < 1)) begin : g_bad_param
      $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             less_q, equal_q, greater_q;
  logic [WIDTH-1:0] msb_flip;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_gt, dig_lt;
  logic             finish;
  res_t             res;

  // Flipping the sign bit maps two's complement onto offset binary.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign dig_a    = a_q[idx_q*DIGIT +: DIGIT];
  assign dig_b    = b_q[idx_q*DIGIT +: DIGIT];

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x  (dig_a),
    .y  (dig_b),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  assign finish = (state_q == SCAN) && (dig_gt || dig_lt || (idx_q == '0));

  always_comb begin
    res = RES_EQ;
    if (dig_lt)      res = RES_LT;
    else if (dig_gt) res = RES_GT;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = SCAN;
      SCAN:    if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      a_q   <= a ^ msb_flip;
      b_q   <= b ^ msb_flip;
      idx_q <= IDX_TOP;
    end else if ((state_q == SCAN) && !finish) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else if (finish) begin
      less_q    <= (res == RES_LT);
      equal_q   <= (res == RES_EQ);
      greater_q <= (res == RES_GT);
    end
  end

  assign busy    = (state_q == SCAN);
  assign done    = (state_q == DONE);
  assign less    = less_q;
  assign equal   = equal_q;
  assign greater = greater_q;

`ifdef CMP_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_lt_q, cnt_eq_q, cnt_gt_q;

  // Clear takes priority, so a completion on the clearing edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lt_q <= '0;
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
    end else if (stats_clr) begin
      cnt_lt_q <= '0;
      cnt_eq_q <= '0;
      cnt_gt_q <= '0;
    end else if (finish) begin
      if ((res == RES_LT) && (cnt_lt_q != CNT_MAX)) cnt_lt_q <= cnt_lt_q + 1'b1;
      if ((res == RES_EQ) && (cnt_eq_q != CNT_MAX)) cnt_eq_q <= cnt_eq_q + 1'b1;
      if ((res == RES_GT) && (cnt_gt_q != CNT_MAX)) cnt_gt_q <= cnt_gt_q + 1'b1;
    end
  end

  assign cnt_less    = cnt_lt_q;
  assign cnt_equal   = cnt_eq_q;
  assign cnt_greater = cnt_gt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// +----------------------------------------------------------------------------+
// | tb_serial_magnitude_comparator : directed + random checks vs. arithmetic   |
// | reference model. Rev 1.0 : initial release                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_magnitude_comparator;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             busy, done, less, equal, greater;
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] cnt_less, cnt_equal, cnt_greater;

  int errors = 0;
  int checks = 0;
  int exp_cl = 0, exp_ce = 0, exp_cg = 0;

  serial_magnitude_comparator #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .less        (less),
    .equal       (equal),
    .greater     (greater)
`ifdef CMP_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .cnt_less    (cnt_less),
    .cnt_equal   (cnt_equal),
    .cnt_greater (cnt_greater)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full compare transaction. clr_edge: edge number (1..) during which
  // stats_clr is held high, 0 for none. poke: pulse start and disturb a mid-scan.
  task automatic run(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                     input int clr_edge, input logic poke, input string tag);
    int ia, ib, lat, got;
    logic el, ee, eg;
    logic [7:0] va, vb;
    ia = ts ? int'($signed(ta)) : int'(ta);
    ib = ts ? int'($signed(tb_)) : int'(tb_);
    el = (ia < ib);
    ee = (ia == ib);
    eg = (ia > ib);
    va = ta;
    vb = tb_;
    lat = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (va[i*DIGIT +: DIGIT] != vb[i*DIGIT +: DIGIT]) begin
        lat = N - i;
        break;
      end
    end

    @(negedge clk);
    a = ta; b = tb_; signed_mode = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      if (poke && k == 2) begin
        start = 1'b1;
        a = 8'hFF;
      end
      stats_clr = (k == clr_edge);
      @(negedge clk);
      start = 1'b0;
      stats_clr = 1'b0;
      if (done) begin
        got = k;
        break;
      end
      chk({tag, "_busy_scan"}, 32'(busy), 32'd1);
    end
    chk({tag, "_latency"}, got, lat);
    chk({tag, "_less"},    32'(less),    32'(el));
    chk({tag, "_equal"},   32'(equal),   32'(ee));
    chk({tag, "_greater"}, 32'(greater), 32'(eg));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);

    if (clr_edge != 0 && clr_edge <= got) begin
      exp_cl = 0; exp_ce = 0; exp_cg = 0;
    end
    if (clr_edge != got) begin
      if (el && exp_cl < 3) exp_cl++;
      if (ee && exp_ce < 3) exp_ce++;
      if (eg && exp_cg < 3) exp_cg++;
    end
`ifdef CMP_STATS_EN
    chk({tag, "_cnt_less"},    32'(cnt_less),    exp_cl);
    chk({tag, "_cnt_equal"},   32'(cnt_equal),   exp_ce);
    chk({tag, "_cnt_greater"}, 32'(cnt_greater), exp_cg);
`endif

    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, {29'd0, less, equal, greater}, {29'd0, el, ee, eg});
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_flags", {29'd0, less, equal, greater}, 32'd0);
`ifdef CMP_STATS_EN
    chk("rst_cnt", {26'd0, cnt_less, cnt_equal, cnt_greater}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_flags", {29'd0, less, equal, greater}, 32'd0);

    // Directed cases
    run(8'h5A, 8'h5A, 1'b0, 0, 1'b0, "eq_5A");
    run(8'hC0, 8'h3F, 1'b0, 0, 1'b0, "u_gt_top");
    run(8'hC0, 8'h3F, 1'b1, 0, 1'b0, "s_lt_top");
    run(8'h12, 8'h13, 1'b0, 0, 1'b1, "u_lt_poke");
    repeat (3) begin
      @(negedge clk);
      chk("no_requeue", {30'd0, busy, done}, 32'd0);
    end

    // Reset in the middle of a scan
    @(negedge clk);
    a = 8'h00; b = 8'h01; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", {29'd0, less, equal, greater}, 32'd0);
    exp_cl = 0; exp_ce = 0; exp_cg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(8'h01, 8'h00, 1'b0, 0, 1'b0, "post_abort");

    // Signed boundary values
    run(8'h80, 8'h7F, 1'b1, 0, 1'b0, "s_min_max");
    run(8'h80, 8'h7F, 1'b0, 0, 1'b0, "u_80_7F");
    run(8'hFF, 8'h00, 1'b1, 0, 1'b0, "s_m1_0");
    run(8'hFE, 8'hFF, 1'b1, 0, 1'b0, "s_m2_m1");

`ifdef CMP_STATS_EN
    // Saturation, then clear colliding with a completion
    run(8'h00, 8'h00, 1'b0, 1, 1'b0, "clr_eq");
    repeat (5) run(8'h33, 8'h33, 1'b0, 0, 1'b0, "sat_eq");
    chk("sat_cnt_equal", 32'(cnt_equal), 32'd3);
    run(8'hC0, 8'h3F, 1'b0, 1, 1'b0, "clr_gt");
    chk("clr_all", {26'd0, cnt_less, cnt_equal, cnt_greater}, 32'd0);
`endif

    // Random compares, biased toward shared upper digits
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ 8'($urandom_range(0, 3));
        2:       rb = ra ^ 8'($urandom_range(0, 15));
        default: rb = 8'($urandom);
      endcase
      run(ra, rb, 1'($urandom), 0, 1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
